dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_array.sv | 44 ++++
 rtl/dmem_responder.sv | 97 +++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and
// byte-lane helper.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int BYTE_W = 8;

   function automatic int lanes(input int data_w);
      return data_w / BYTE_W;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x DATA_W RAM with per-byte write enables and a registered
// read port; each byte lane is its own narrow array so it maps onto block RAM.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [lanes(DATA_W)-1:0] wstrb,
   output logic [DATA_W-1:0]        rdata
);

   localparam int LANES = lanes(DATA_W);

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [BYTE_W-1:0] mem [DEPTH];
         logic [BYTE_W-1:0] q_reg;

         // Output register only loads on reads, so it holds across a stalled response.
         always_ff @(posedge clk) begin
            if (en) begin
               if (we) begin
                  if (wstrb[gi]) begin
                     mem[addr] <= wdata[gi*BYTE_W +: BYTE_W];
                  end
               end else begin
                  q_reg <= mem[addr];
               end
            end
         end

         assign rdata[gi*BYTE_W +: BYTE_W] = q_reg;
      end
   endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the CPU load/store interface: one request at a time, response
// presented a fixed LATENCY after the request cycle, held until accepted.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic [DATA_W-1:0]        req_wdata,
   input  logic [lanes(DATA_W)-1:0] req_wstrb,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [DATA_W-1:0]        resp_rdata,
   output logic                     resp_err
);

   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

   state_t             state_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               rd_sel_reg;
   logic               err_reg;
   logic               accept;
   logic               in_range;
   logic [DATA_W-1:0]  ram_q;

   assign req_ready  = (state_reg == IDLE);
   assign resp_valid = (state_reg == RESP);
   assign accept     = req_valid && req_ready;
   // Extra MSB keeps the compare meaningful when DEPTH == 2**ADDR_W.
   assign in_range   = ({1'b0, req_addr} < DEPTH_V);

   dmem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .en    (accept && in_range),
      .we    (req_we),
      .addr  (req_addr),
      .wdata (req_wdata),
      .wstrb (req_wstrb),
      .rdata (ram_q)
   );

   // The RAM output register is the read-data holding register; writes and errors mask it to zero.
   assign resp_rdata = rd_sel_reg ? ram_q : '0;
   assign resp_err   = err_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         rd_sel_reg <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  rd_sel_reg <= in_range && !req_we;
                  err_reg    <= !in_range;
                  if (LATENCY == 1) begin
                     state_reg <= RESP;
                  end else begin
                     state_reg <= WAIT;
                     cnt_reg   <= CNT_W'(LATENCY - 2);
                  end
               end
            end
            WAIT: begin
               if (cnt_reg == '0) begin
                  state_reg <= RESP;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
